vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA driver. Generates the h/v sync, data-enable and pixel-address stream for any video mode set by parameters, with configurable sync polarity. Compensates a fixed-latency pixel source (ROM or frame buffer) so sync, DE and RGB leave the block aligned. A run/stop state machine starts and stops output only at frame boundaries. Sits between the pixel-clock PLL output and the DAC/HDMI encoder.

---
 rtl/vga_pkg.sv | 67 ++++++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared video-mode tables, run/stop state codes, pipeline flag payload and colour-bar values.
// The test-pattern build is selected with the VGA_TEST_PATTERN_EN macro.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned M640_H_SYNC  = 96;
  localparam int unsigned M640_H_BACK  = 48;
  localparam int unsigned M640_H_ACT   = 640;
  localparam int unsigned M640_H_FRONT = 16;
  localparam int unsigned M640_V_SYNC  = 2;
  localparam int unsigned M640_V_BACK  = 33;
  localparam int unsigned M640_V_ACT   = 480;
  localparam int unsigned M640_V_FRONT = 10;
  localparam logic        M640_HS_POL  = 1'b0;
  localparam logic        M640_VS_POL  = 1'b0;

  // 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs
  localparam int unsigned M800_H_SYNC  = 120;
  localparam int unsigned M800_H_BACK  = 64;
  localparam int unsigned M800_H_ACT   = 800;
  localparam int unsigned M800_H_FRONT = 56;
  localparam int unsigned M800_V_SYNC  = 6;
  localparam int unsigned M800_V_BACK  = 23;
  localparam int unsigned M800_V_ACT   = 600;
  localparam int unsigned M800_V_FRONT = 37;
  localparam logic        M800_HS_POL  = 1'b1;
  localparam logic        M800_VS_POL  = 1'b1;

  localparam int unsigned RGB_W     = 24;
  localparam int unsigned DRAIN_W   = 4;
  localparam int unsigned BAR_COUNT = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Sync/active/frame flags as asserted booleans; polarity is applied at the output register
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } vga_flags_t;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with read-latency compensation and frame-aligned run/stop.
// Define VGA_TEST_PATTERN_EN to replace rgb_data_i with eight vertical colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC  = M640_H_SYNC,
  parameter int unsigned H_BACK  = M640_H_BACK,
  parameter int unsigned H_ACT   = M640_H_ACT,
  parameter int unsigned H_FRONT = M640_H_FRONT,
  parameter int unsigned V_SYNC  = M640_V_SYNC,
  parameter int unsigned V_BACK  = M640_V_BACK,
  parameter int unsigned V_ACT   = M640_V_ACT,
  parameter int unsigned V_FRONT = M640_V_FRONT,
  parameter logic        HS_POL  = M640_HS_POL,
  parameter logic        VS_POL  = M640_VS_POL,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned CNT_W   = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [23:0]      rgb_data_i,
  output logic             req_o,
  output logic [CNT_W-1:0] addr_h_o,
  output logic [CNT_W-1:0] addr_v_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             de_o,
  output logic [7:0]       rgb_r_o,
  output logic [7:0]       rgb_g_o,
  output logic [7:0]       rgb_b_o,
  output logic             frame_start_o,
  output logic             busy_o
);

  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int unsigned HA_START = H_SYNC + H_BACK;
  localparam int unsigned HA_END   = HA_START + H_ACT;
  localparam int unsigned VA_START = V_SYNC + V_BACK;
  localparam int unsigned VA_END   = VA_START + V_ACT;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0]   cnt_v_q, cnt_v_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_q;
  logic               h_last, v_last;

  assign h_last = (cnt_h_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (cnt_v_q == CNT_W'(V_TOTAL - 1));

  // Run/stop control; stop requests only take effect on the last count of a frame
  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        drain_d = '0;
        if (en_i) state_d = S_RUN;
      end
      S_RUN: begin
        drain_d = '0;
        if (h_last) begin
          cnt_h_d = '0;
          if (v_last) begin
            cnt_v_d = '0;
            if (!en_i) state_d = S_DRAIN;
          end else begin
            cnt_v_d = cnt_v_q + CNT_W'(1);
          end
        end else begin
          cnt_h_d = cnt_h_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        if (drain_q == DRAIN_W'(RD_LAT)) begin
          state_d = S_IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_h_d = '0;
        cnt_v_d = '0;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      drain_q <= drain_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Stage 1: request, address and raw flags decoded from the counters
  logic             req_d, req_q;
  logic [CNT_W-1:0] addr_h_d, addr_h_q;
  logic [CNT_W-1:0] addr_v_d, addr_v_q;
  vga_flags_t       flags_d, flags_q;
  logic             h_act, v_act;

  assign h_act = (cnt_h_q >= CNT_W'(HA_START)) && (cnt_h_q < CNT_W'(HA_END));
  assign v_act = (cnt_v_q >= CNT_W'(VA_START)) && (cnt_v_q < CNT_W'(VA_END));

  always_comb begin
    req_d    = 1'b0;
    addr_h_d = '0;
    addr_v_d = '0;
    flags_d  = '0;
    if (state_q == S_RUN) begin
      flags_d.hs  = (cnt_h_q < CNT_W'(H_SYNC));
      flags_d.vs  = (cnt_v_q < CNT_W'(V_SYNC));
      flags_d.act = h_act && v_act;
      flags_d.fs  = (cnt_h_q == '0) && (cnt_v_q == '0);
      if (h_act && v_act) begin
        req_d    = 1'b1;
        addr_h_d = cnt_h_q - CNT_W'(HA_START);
        addr_v_d = cnt_v_q - CNT_W'(VA_START);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= 1'b0;
      addr_h_q <= '0;
      addr_v_q <= '0;
      flags_q  <= '0;
    end else begin
      req_q    <= req_d;
      addr_h_q <= addr_h_d;
      addr_v_q <= addr_v_d;
      flags_q  <= flags_d;
    end
  end

  // Flags wait RD_LAT clocks so the output register meets the source's data
  vga_flags_t flags_dly;

  vga_delay_line #(
    .DEPTH(RD_LAT),
    .WIDTH($bits(vga_flags_t))
  ) u_flag_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (flags_q),
    .q_o  (flags_dly)
  );

  logic [RGB_W-1:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = ((H_ACT / BAR_COUNT) == 0) ? 1 : (H_ACT / BAR_COUNT);

  logic [CNT_W-1:0] bar_pos;
  logic [2:0]       bar_d, bar_q, bar_dly;
  logic             unused_rgb_data;

  assign unused_rgb_data = ^rgb_data_i;

  always_comb begin
    bar_pos = addr_h_d / CNT_W'(BAR_W);
    bar_d   = (bar_pos > CNT_W'(BAR_COUNT - 1)) ? 3'(BAR_COUNT - 1) : bar_pos[2:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bar_q <= '0;
    else       bar_q <= bar_d;
  end

  vga_delay_line #(
    .DEPTH(RD_LAT),
    .WIDTH(3)
  ) u_bar_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (bar_q),
    .q_o  (bar_dly)
  );

  assign pix = bar_colour(bar_dly);
`else
  assign pix = rgb_data_i;
`endif

  // Output register: polarity applied, colour blanked outside the active area
  logic             h_sync_q, v_sync_q, de_q, fs_q;
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_sync_q <= ~HS_POL;
      v_sync_q <= ~VS_POL;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      h_sync_q <= flags_dly.hs ? HS_POL : ~HS_POL;
      v_sync_q <= flags_dly.vs ? VS_POL : ~VS_POL;
      de_q     <= flags_dly.act;
      fs_q     <= flags_dly.fs;
      rgb_q    <= flags_dly.act ? pix : '0;
    end
  end

  assign req_o         = req_q;
  assign addr_h_o      = addr_h_q;
  assign addr_v_o      = addr_v_q;
  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign de_o          = de_q;
  assign rgb_r_o       = rgb_q[23:16];
  assign rgb_g_o       = rgb_q[15:8];
  assign rgb_b_o       = rgb_q[7:0];
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three small-mode instances (RD_LAT 2/0/4, one with positive syncs)
// checked every clock against a frame-position reference model.
module tb_vga_timing_gen;

  localparam int NI    = 3;
  localparam int CW    = 12;
  localparam int HS_W  = 2;
  localparam int HB_W  = 2;
  localparam int HF_W  = 2;
  localparam int VS_W  = 1;
  localparam int VB_W  = 1;
  localparam int VA_W  = 3;
  localparam int V_TOT = 6;

  typedef struct {
    int          inst;
    int          due;
    bit          is_out;
    bit          flag;
    int          ah;
    int          av;
    bit          busy;
    bit          hs;
    bit          vs;
    bit          fs;
    logic [23:0] rgb;
  } exp_t;

  function automatic int hact_of(input int i);
    return (i == 2) ? 16 : 4;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 4);
  endfunction

  function automatic int pol_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic logic [23:0] src_fn(input int h, input int v);
    return {8'((v * 37 + 17) & 255), 8'((h * 11 + 3) & 255), 8'((h + v * 16) & 255)};
  endfunction

  function automatic logic [23:0] bar_rgb(input int ah, input int ha);
    int bw;
    int idx;
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bw  = (ha / 8 < 1) ? 1 : ha / 8;
    idx = ah / bw;
    if (idx > 7) idx = 7;
    return tbl[idx];
  endfunction

  function automatic logic [23:0] pix_of(input int ah, input int av, input int ha);
`ifdef VGA_TEST_PATTERN_EN
    return bar_rgb(ah, ha) ^ (24'(av) & 24'h0);
`else
    return src_fn(ah, av) ^ (24'(ha) & 24'h0);
`endif
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [23:0]   rgb_data [NI];
  logic          req      [NI];
  logic [CW-1:0] addr_h   [NI];
  logic [CW-1:0] addr_v   [NI];
  logic          hsync    [NI];
  logic          vsync    [NI];
  logic          de       [NI];
  logic [7:0]    rr       [NI];
  logic [7:0]    gg       [NI];
  logic [7:0]    bb       [NI];
  logic          fs       [NI];
  logic          busy     [NI];
  logic [23:0]   src_pipe [NI][8];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .CNT_W(CW)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rgb_data_i(rgb_data[0]),
    .req_o(req[0]), .addr_h_o(addr_h[0]), .addr_v_o(addr_v[0]),
    .h_sync_o(hsync[0]), .v_sync_o(vsync[0]), .de_o(de[0]),
    .rgb_r_o(rr[0]), .rgb_g_o(gg[0]), .rgb_b_o(bb[0]),
    .frame_start_o(fs[0]), .busy_o(busy[0])
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(0), .CNT_W(CW)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rgb_data_i(rgb_data[1]),
    .req_o(req[1]), .addr_h_o(addr_h[1]), .addr_v_o(addr_v[1]),
    .h_sync_o(hsync[1]), .v_sync_o(vsync[1]), .de_o(de[1]),
    .rgb_r_o(rr[1]), .rgb_g_o(gg[1]), .rgb_b_o(bb[1]),
    .frame_start_o(fs[1]), .busy_o(busy[1])
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACT(16), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(4), .CNT_W(CW)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rgb_data_i(rgb_data[2]),
    .req_o(req[2]), .addr_h_o(addr_h[2]), .addr_v_o(addr_v[2]),
    .h_sync_o(hsync[2]), .v_sync_o(vsync[2]), .de_o(de[2]),
    .rgb_r_o(rr[2]), .rgb_g_o(gg[2]), .rgb_b_o(bb[2]),
    .frame_start_o(fs[2]), .busy_o(busy[2])
  );

  // Pixel sources: data for an address appears lat_of(i) clocks after it is requested
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        for (int k = 7; k > 0; k--) src_pipe[i][k] <= src_pipe[i][k-1];
        src_pipe[i][0] <= src_fn(int'(addr_h[i]), int'(addr_v[i]));
      end
    end
  end

  assign rgb_data[0] = src_pipe[0][1];
  assign rgb_data[1] = src_fn(int'(addr_h[1]), int'(addr_v[1]));
  assign rgb_data[2] = src_pipe[2][3];

  exp_t sb [$];
  int   ecnt   = 0;
  int   errors = 0;
  int   checks = 0;
  int   mstate [NI];
  int   mk     [NI];
  int   mdr    [NI];

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge=%0d got=%0h exp=%0h", name, i, ecnt, got, exp);
    end
  endtask

  // Reference: mstate 0=stopped 1=scanning pixel mk 2=flushing; position from mk by div/mod
  task automatic model_step(input int i, input logic run_req);
    int   ht;
    int   h;
    int   v;
    bit   act;
    exp_t s1;
    exp_t o;
    ht = HS_W + HB_W + hact_of(i) + HF_W;
    s1 = '{inst: i, due: ecnt, is_out: 1'b0, flag: 1'b0, ah: 0, av: 0, busy: 1'b0,
           hs: 1'b0, vs: 1'b0, fs: 1'b0, rgb: 24'h0};
    o  = s1;
    o.is_out = 1'b1;
    o.due    = ecnt + lat_of(i) + 1;
    if (mstate[i] == 1) begin
      h   = mk[i] % ht;
      v   = mk[i] / ht;
      act = (h >= HS_W + HB_W) && (h < HS_W + HB_W + hact_of(i)) &&
            (v >= VS_W + VB_W) && (v < VS_W + VB_W + VA_W);
      s1.flag = act;
      s1.ah   = act ? h - HS_W - HB_W : 0;
      s1.av   = act ? v - VS_W - VB_W : 0;
      o.flag  = act;
      o.hs    = (h < HS_W);
      o.vs    = (v < VS_W);
      o.fs    = (mk[i] == 0);
      o.rgb   = act ? pix_of(s1.ah, s1.av, hact_of(i)) : 24'h0;
    end
    case (mstate[i])
      0: if (run_req) begin mstate[i] = 1; mk[i] = 0; end
      1: begin
        if (mk[i] == ht * V_TOT - 1) begin
          if (run_req) mk[i] = 0;
          else begin mstate[i] = 2; mdr[i] = 0; end
        end else begin
          mk[i]++;
        end
      end
      default: begin
        if (mdr[i] == lat_of(i)) mstate[i] = 0;
        else mdr[i]++;
      end
    endcase
    s1.busy = (mstate[i] != 0);
    sb.push_back(s1);
    sb.push_back(o);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sb.delete();
        ecnt = 0;
        for (int i = 0; i < NI; i++) begin
          mstate[i] = 0;
          mk[i]     = 0;
          mdr[i]    = 0;
        end
      end else begin
        ecnt++;
        for (int i = 0; i < NI; i++) model_step(i, en);
      end
    end
  end

  task automatic compare_entry(input exp_t e);
    int i;
    int ip;
    i  = e.inst;
    ip = 1 - pol_of(i);
    if (!e.is_out) begin
      chk("req",    i, 32'(req[i]),    32'(e.flag));
      chk("addr_h", i, 32'(addr_h[i]), 32'(e.ah));
      chk("addr_v", i, 32'(addr_v[i]), 32'(e.av));
      chk("busy",   i, 32'(busy[i]),   32'(e.busy));
    end else begin
      chk("h_sync",      i, 32'(hsync[i]), 32'(e.hs ? pol_of(i) : ip));
      chk("v_sync",      i, 32'(vsync[i]), 32'(e.vs ? pol_of(i) : ip));
      chk("de",          i, 32'(de[i]),    32'(e.flag));
      chk("frame_start", i, 32'(fs[i]),    32'(e.fs));
      chk("rgb",         i, 32'({rr[i], gg[i], bb[i]}), 32'(e.rgb));
    end
  endtask

  exp_t keep [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        keep = {};
        foreach (sb[j]) begin
          if (sb[j].due == ecnt) compare_entry(sb[j]);
          else if (sb[j].due > ecnt) keep.push_back(sb[j]);
        end
        sb = keep;
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_req"},    i, 32'(req[i]),    32'd0);
      chk({tag, "_addr"},   i, 32'({addr_h[i], addr_v[i]}), 32'd0);
      chk({tag, "_de"},     i, 32'(de[i]),     32'd0);
      chk({tag, "_rgb"},    i, 32'({rr[i], gg[i], bb[i]}), 32'd0);
      chk({tag, "_fs"},     i, 32'(fs[i]),     32'd0);
      chk({tag, "_busy"},   i, 32'(busy[i]),   32'd0);
      chk({tag, "_h_sync"}, i, 32'(hsync[i]),  32'(1 - pol_of(i)));
      chk({tag, "_v_sync"}, i, 32'(vsync[i]),  32'(1 - pol_of(i)));
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while ((busy[0] || busy[1] || busy[2]) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_idle_in_time"}, 0, 32'(waited < 2000), 32'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_idle_busy"},   i, 32'(busy[i]),  32'd0);
      chk({tag, "_idle_h_sync"}, i, 32'(hsync[i]), 32'(1 - pol_of(i)));
      chk({tag, "_idle_v_sync"}, i, 32'(vsync[i]), 32'(1 - pol_of(i)));
      chk({tag, "_idle_de"},     i, 32'(de[i]),    32'd0);
    end
  endtask

  task automatic random_en(input int bursts);
    for (int n = 0; n < bursts; n++) begin
      en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 180)) @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    en = 1'b1;
    rst = 1'b0;

    // First frame of dut0 yields its stage-1 outputs after edges 2..61
    @(negedge clk);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (req[0]) cnt++;
    end
    chk("req_per_frame", 0, 32'(cnt), 32'd12);

    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!hsync[0]) cnt++;
    end
    chk("h_sync_low_per_line", 0, 32'(cnt), 32'd2);

    repeat (150) @(negedge clk);
    random_en(25);
    en = 1'b0;
    wait_idle("stop1");

    en = 1'b1;
    repeat ($urandom_range(30, 100)) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    random_en(10);
    en = 1'b0;
    wait_idle("stop2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
